// File: rtl/hit_judge_if.sv
// Bundle of the timing strobe, note/key inputs and judgement/statistics
// outputs exchanged between the note scheduler and the hit judge.
interface hit_judge_if #(
  parameter int CNT_W = 10
);
  logic             tick;
  logic             note_valid;
  logic             key_press;
  logic [1:0]       judgement;
  logic             judge_valid;
  logic [CNT_W-1:0] perfect_cnt;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] combo;

  modport master (
    output tick, note_valid, key_press,
    input  judgement, judge_valid, perfect_cnt, good_cnt, miss_cnt, combo
  );

  modport slave (
    input  tick, note_valid, key_press,
    output judgement, judge_valid, perfect_cnt, good_cnt, miss_cnt, combo
  );
endinterface

// File: rtl/hit_judge.sv
// Single-lane rhythm-game timing judge: classifies each note as PERFECT, GOOD
// or MISS from the note/press tick distance and keeps per-song statistics.
module hit_judge #(
  parameter int PERFECT_WIN = 2,
  parameter int GOOD_WIN    = 5,
  parameter int HOLD_TICKS  = 500,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  hit_judge_if.slave  bus
);
  localparam int AGE_W  = $clog2(GOOD_WIN + 2);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [AGE_W-1:0]  P_WIN     = AGE_W'(PERFECT_WIN);
  localparam logic [AGE_W-1:0]  G_WIN     = AGE_W'(GOOD_WIN);
  localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(GOOD_WIN + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  localparam logic [1:0] J_PERFECT = 2'b00;
  localparam logic [1:0] J_GOOD    = 2'b01;
  localparam logic [1:0] J_MISS    = 2'b10;
  localparam logic [1:0] J_NONE    = 2'b11;

  typedef enum logic {IDLE, PENDING} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state, state_n;
  logic              key_q;
  logic              press_ev;
  logic              armed;
  logic [AGE_W-1:0]  press_age;
  logic [AGE_W-1:0]  note_age, note_age_n;
  logic [HOLD_W-1:0] hold;
  logic              issue;
  logic              consume;
  logic [1:0]        res;

  assign press_ev = bus.key_press & ~key_q;

  // Decision: a pending note is always resolved before a new one is queued,
  // and a press resolves at most one note.
  always_comb begin
    issue      = 1'b0;
    consume    = 1'b0;
    res        = J_NONE;
    state_n    = state;
    note_age_n = note_age;
    case (state)
      IDLE: begin
        if (bus.note_valid) begin
          if (press_ev) begin
            issue   = 1'b1;
            consume = 1'b1;
            res     = J_PERFECT;
          end else if (armed) begin
            issue   = 1'b1;
            consume = 1'b1;
            res     = (press_age <= P_WIN) ? J_PERFECT : J_GOOD;
          end else begin
            state_n    = PENDING;
            note_age_n = '0;
          end
        end
      end
      PENDING: begin
        if (bus.tick) note_age_n = note_age + AGE_W'(1);
        if (press_ev) begin
          issue   = 1'b1;
          consume = 1'b1;
          res     = (note_age <= P_WIN) ? J_PERFECT : J_GOOD;
          state_n = IDLE;
        end else if (bus.note_valid) begin
          issue = 1'b1;
          res   = J_MISS;
        end else if (bus.tick && note_age == G_WIN) begin
          issue   = 1'b1;
          res     = J_MISS;
          state_n = IDLE;
        end
        if (bus.note_valid) begin
          state_n    = PENDING;
          note_age_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      note_age  <= '0;
      key_q     <= 1'b0;
      armed     <= 1'b0;
      press_age <= '0;
    end else begin
      state    <= state_n;
      note_age <= note_age_n;
      key_q    <= bus.key_press;
      if (press_ev) begin
        press_age <= '0;
        armed     <= !consume;
      end else begin
        if (bus.tick && press_age != AGE_MAX) press_age <= press_age + AGE_W'(1);
        if (consume || (bus.tick && press_age >= G_WIN)) armed <= 1'b0;
      end
    end
  end

  // Output register: judgement with hold timer, and the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.judgement   <= J_NONE;
      bus.judge_valid <= 1'b0;
      bus.perfect_cnt <= '0;
      bus.good_cnt    <= '0;
      bus.miss_cnt    <= '0;
      bus.combo       <= '0;
      hold            <= '0;
    end else begin
      bus.judge_valid <= issue;
      if (issue) begin
        bus.judgement <= res;
        hold          <= HOLD_LOAD;
        case (res)
          J_PERFECT: bus.perfect_cnt <= sat_inc(bus.perfect_cnt);
          J_GOOD:    bus.good_cnt    <= sat_inc(bus.good_cnt);
          default:   bus.miss_cnt    <= sat_inc(bus.miss_cnt);
        endcase
        bus.combo <= (res == J_MISS) ? '0 : sat_inc(bus.combo);
      end else if (bus.tick && hold != '0) begin
        hold <= hold - HOLD_W'(1);
        if (hold == HOLD_W'(1)) bus.judgement <= J_NONE;
      end
    end
  end
endmodule

// File: doc/hit_judge.md
# hit_judge

Single-lane timing judge for the rhythm game. Compares each note's arrival at the judge line with the player's key press, classifies the hit as PERFECT, GOOD or MISS, and keeps per-song statistics. Its `judgement` output drives the two-digit current-judgement 7-segment decoder directly and uses the same 2-bit encoding. Sits between the note scheduler (upstream) and the display/score path (downstream).

## Interface
- `PERFECT_WIN`, 2: half-width of the PERFECT window, in ticks.
- `GOOD_WIN`, 5: half-width of the GOOD window, in ticks; must exceed `PERFECT_WIN`.
- `HOLD_TICKS`, 500: ticks a judgement stays on `judgement` before reverting to NO_NOTE.
- `CNT_W`, 10: width of the statistic counters.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle timebase strobe (1 ms); all ages and hold timers advance only on `tick`.
- `note_valid`  in  1  one-cycle pulse: a note reaches the judge line this cycle.
- `key_press`  in  1  debounced, synchronous key level.
- `judgement`  out  2  00 PERFECT, 01 GOOD, 10 MISS, 11 NO_NOTE.
- `judge_valid`  out  1  one-cycle pulse when a new judgement is issued.
- `perfect_cnt`, `good_cnt`, `miss_cnt`  out  CNT_W  saturating totals.
- `combo`  out  CNT_W  consecutive non-MISS count, saturating.

## Operation
- Press event: cycle where `key_press`=1 and the previous-cycle sample was 0. Holding the key does not create further events.
- Press tracker: on a press event, `press_age`<=0 and `armed`<=1; later press events restart it. On `tick`, `press_age` increments, saturating at GOOD_WIN+1; `armed` clears when the age would exceed GOOD_WIN. A press consumed by a judgement clears `armed`.
- FSM states IDLE and PENDING.
  - IDLE, `note_valid`, `armed` (or press event this cycle, age 0): `press_age`<=PERFECT_WIN -> PERFECT; otherwise -> GOOD. Stays IDLE and consumes the press.
  - IDLE, `note_valid`, not armed: -> PENDING with `note_age`=0.
  - PENDING: `note_age` increments on `tick`. On a press event, `note_age`<=PERFECT_WIN -> PERFECT, otherwise GOOD, then -> IDLE. On `tick` with `note_age`==GOOD_WIN and no press event -> MISS, then -> IDLE.
  - PENDING with `note_valid`: the pending note resolves first. A same-cycle press event judges it by `note_age`; otherwise it is MISS. The new note enters PENDING with `note_age`=0. The press is not reused for the new note.
  - A press with no note pending only arms the tracker. It never generates MISS.
- Issuing a judgement:
  - Load `judgement`, pulse `judge_valid`, reload the hold timer to HOLD_TICKS.
  - Increment the matching counter, saturating at 2^CNT_W-1.
  - `combo`+1 (saturating) on PERFECT/GOOD; `combo`<=0 on MISS.
- Hold timer decrements on `tick`. At 0, `judgement`<=11 (NO_NOTE). A new judgement during the hold replaces the value and restarts the timer.

## Timing
- Reset values: `judgement`=11, `judge_valid`=0, all counters and `combo`=0, FSM=IDLE, `armed`=0, ages=0.
- Reset asserted mid-operation discards any pending note without a MISS.
- Latency: `judgement`/`judge_valid` register on the rising edge that ends the cycle containing the deciding event (`note_valid`, press event, or expiring `tick`). One cycle total.
- Counters and `combo` update on the same edge as `judge_valid`.
- `judge_valid` is high for exactly one cycle per judgement. At most one judgement per cycle.
- Simultaneous `tick` and press event in PENDING: the press wins, judged by `note_age` before the increment.

## Test plan
- Press, then `note_valid` 1 tick later -> `judgement`=00, `judge_valid` one cycle, `perfect_cnt`=1, `combo`=1.
- `note_valid`, press 4 ticks later -> 01, `good_cnt`=1.
- `note_valid`, no press -> MISS after the 6th tick (`note_age`==5 at expiry), `miss_cnt`=1, `combo`=0. A later press produces no judgement.
- Two notes 3 ticks apart, no press -> first MISS on the second `note_valid`, second MISS 6 ticks later. Repeat with a press in the same cycle as the second note -> first GOOD, second later MISS.
- After PERFECT, `judgement` holds 00 for 500 ticks, then 11. A judgement at tick 300 restarts the hold.
- `rst_n` low while PENDING -> all outputs return to reset values immediately (asynchronously); no MISS counted. With CNT_W=2, four PERFECTs leave `perfect_cnt`=3.
